// File: rtl/ham_pkg.sv
// Shared types and helpers for the Hamming-distance engine and its arbiter.
package ham_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Count width needed to represent 0..n.
    function automatic int cw(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic bit params_ok(input int n, input int r, input int s);
        return (s >= 1) && (s <= n) && ((n % s) == 0) && (r >= 2) && (r <= 16);
    endfunction

endpackage

// File: rtl/ham_rr_arb.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps.
module ham_rr_arb #(
    parameter int R = 4,
    localparam int IW = $clog2(R)
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [R-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= R; k++) begin
            cand = IW'((int'(ptr) + k) % R);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/ham_dist_sched.sv
// Shared serial Hamming-distance engine; one granted requester at a time,
// S bits of the latched XOR are counted per cycle.
module ham_dist_sched
    import ham_pkg::*;
#(
    parameter int N = 8,
    parameter int R = 4,
    parameter int S = 2,
    localparam int IW = $clog2(R),
    localparam int CW = cw(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*N-1:0] req_a,
    input  logic [R*N-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IW-1:0]  rsp_id,
    output logic [CW-1:0]  rsp_count
);

    localparam int NB = N / S;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PW = $clog2(S + 1);

    if (!params_ok(N, R, S)) begin : g_bad_params
        $error("ham_dist_sched: illegal parameter combination");
    end

    state_t        state_reg;
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] id_reg;
    logic [CW-1:0] acc_reg;
    logic [N-1:0]  diff_reg;
    logic [BW-1:0] beat_reg;

    logic [N-1:0]  a_arr [R];
    logic [N-1:0]  b_arr [R];
    logic [R-1:0]  grant;
    logic [IW-1:0] win_idx;
    logic          win_any;
    logic [PW-1:0] beat_pop;

    for (genvar gi = 0; gi < R; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*N +: N];
        assign b_arr[gi] = req_b[gi*N +: N];
    end

    ham_rr_arb #(.R(R)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_comb begin
        beat_pop = '0;
        for (int i = 0; i < S; i++) begin
            beat_pop = beat_pop + PW'(diff_reg[i]);
        end
    end

    // Grant is offered only in IDLE, so a handshake can never overlap a job.
    assign req_ready = (state_reg == IDLE) ? grant : '0;
    assign rsp_valid = (state_reg == DONE);
    assign rsp_count = acc_reg;
    assign rsp_id    = id_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= IW'(R - 1);
            id_reg    <= '0;
            acc_reg   <= '0;
            diff_reg  <= '0;
            beat_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_any) begin
                        diff_reg  <= a_arr[win_idx] ^ b_arr[win_idx];
                        id_reg    <= win_idx;
                        ptr_reg   <= win_idx;
                        acc_reg   <= '0;
                        beat_reg  <= '0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    acc_reg  <= acc_reg + CW'(beat_pop);
                    diff_reg <= diff_reg >> S;
                    if (beat_reg == BW'(NB - 1)) begin
                        state_reg <= DONE;
                    end else begin
                        beat_reg <= beat_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ham_dist_sched.sv
// Directed bench for ham_dist_sched: S=2 main instance plus S=1 and S=8 copies on shared stimulus.
module tb_ham_dist_sched;

    localparam int N = 8;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [R-1:0]   req_valid = '0;
    logic [R*N-1:0] req_a = '0;
    logic [R*N-1:0] req_b = '0;
    logic           rsp_ready = 1'b1;

    logic [R-1:0] req_ready2, req_ready1, req_ready8;
    logic         rsp_valid2, rsp_valid1, rsp_valid8;
    logic [1:0]   rsp_id2, rsp_id1, rsp_id8;
    logic [3:0]   rsp_count2, rsp_count1, rsp_count8;

    always #5 clk = ~clk;

    ham_dist_sched #(.N(N), .R(R), .S(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id2), .rsp_count(rsp_count2)
    );

    ham_dist_sched #(.N(N), .R(R), .S(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id1), .rsp_count(rsp_count1)
    );

    ham_dist_sched #(.N(N), .R(R), .S(8)) dut_s8 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready8),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id8), .rsp_count(rsp_count8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_ops(input int r, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[r*N +: N] = a;
        req_b[r*N +: N] = b;
    endtask

    typedef struct {
        int         r;
        logic [7:0] a;
        logic [7:0] b;
        int         cnt;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lat2, lat1, lat8;
        int c2, c1, c8, id2;
        int n;
        int ids [8];
        int cnts [8];
        int cyc [8];
        bit seen;
        bit bad;

        vecs[0] = '{0, 8'hFF, 8'h0F, 4};
        vecs[1] = '{1, 8'hA5, 8'hA5, 0};
        vecs[2] = '{2, 8'h00, 8'hFF, 8};
        vecs[3] = '{3, 8'h01, 8'h80, 2};
        vecs[4] = '{0, 8'h3C, 8'h00, 4};
        vecs[5] = '{1, 8'h55, 8'hAA, 8};
        vecs[6] = '{2, 8'h12, 8'h13, 1};
        vecs[7] = '{3, 8'h6E, 8'h64, 2};

        // Reset state
        do_reset();
        #1;
        chk("reset_outputs", {21'd0, rsp_valid2, rsp_count2, rsp_id2, req_ready2}, 32'd0);
        chk("reset_outputs_s1", {21'd0, rsp_valid1, rsp_count1, rsp_id1, req_ready1}, 32'd0);

        // Single-request vectors: latency, count, id, operand release
        for (int v = 0; v < 8; v++) begin
            do_reset();
            @(negedge clk);
            set_ops(vecs[v].r, vecs[v].a, vecs[v].b);
            req_valid = '0;
            req_valid[vecs[v].r] = 1'b1;
            #1;
            chk($sformatf("v%0d_req_ready", v), 32'(req_ready2), 32'(1 << vecs[v].r));
            @(negedge clk);
            req_valid = '0;
            req_a = req_a ^ 32'h3C3C_3C3C;
            req_b = req_b ^ 32'hC3C3_0F0F;
            lat2 = 0; lat1 = 0; lat8 = 0;
            c2 = -1; c1 = -1; c8 = -1; id2 = -1;
            for (int k = 1; k <= 20; k++) begin
                if (k > 1) @(negedge clk);
                #1;
                if (rsp_valid2 && lat2 == 0) begin lat2 = k; c2 = int'(rsp_count2); id2 = int'(rsp_id2); end
                if (rsp_valid1 && lat1 == 0) begin lat1 = k; c1 = int'(rsp_count1); end
                if (rsp_valid8 && lat8 == 0) begin lat8 = k; c8 = int'(rsp_count8); end
            end
            chk($sformatf("v%0d_lat_s2", v), lat2, 5);
            chk($sformatf("v%0d_lat_s1", v), lat1, 9);
            chk($sformatf("v%0d_lat_s8", v), lat8, 2);
            chk($sformatf("v%0d_cnt_s2", v), c2, vecs[v].cnt);
            chk($sformatf("v%0d_cnt_s1", v), c1, vecs[v].cnt);
            chk($sformatf("v%0d_cnt_s8", v), c8, vecs[v].cnt);
            chk($sformatf("v%0d_id", v), id2, vecs[v].r);
        end

        // Fairness: all requesters valid, rsp_ready high
        do_reset();
        @(negedge clk);
        for (int r = 0; r < R; r++) set_ops(r, 8'((1 << (r + 1)) - 1), 8'h00);
        req_valid = 4'b1111;
        n = 0;
        for (int k = 0; k < 100 && n < 8; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid2) begin
                ids[n]  = int'(rsp_id2);
                cnts[n] = int'(rsp_count2);
                cyc[n]  = k;
                n++;
            end
        end
        req_valid = '0;
        chk("fair_results", n, 8);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("fair_id%0d", i), ids[i], i % 4);
            chk($sformatf("fair_cnt%0d", i), cnts[i], (i % 4) + 1);
            if (i > 0) chk($sformatf("fair_gap%0d", i), cyc[i] - cyc[i-1], 6);
        end

        // Backpressure: hold DONE with other requesters pending
        do_reset();
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int r = 0; r < R; r++) set_ops(r, 8'h0F, 8'h00);
        set_ops(2, 8'hFF, 8'h00);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b1011;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid2) seen = 1'b1;
        end
        chk("bp_rsp_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp_hold%0d", k), {21'd0, rsp_valid2, rsp_count2, rsp_id2, req_ready2},
                {21'd0, 1'b1, 4'd8, 2'd2, 4'b0000});
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        chk("bp_accept_no_grant", 32'(req_ready2), 32'd0);
        chk("bp_accept_valid", 32'(rsp_valid2), 32'd1);
        @(negedge clk);
        #1;
        chk("bp_after_valid", 32'(rsp_valid2), 32'd0);
        chk("bp_after_grant", 32'(req_ready2), 32'b1000);

        // Mid-operation reset at BUSY beat 2
        do_reset();
        @(negedge clk);
        set_ops(1, 8'hFF, 8'h00);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {21'd0, rsp_valid2, rsp_count2, rsp_id2, req_ready2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid2 !== 1'b0) bad = 1'b1;
        end
        chk("midrst_no_rsp", 32'(bad), 32'd0);
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("midrst_next_grant", 32'(req_ready2), 32'b0001);
        @(negedge clk);
        req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
